// File: rtl/i2c_pkg.sv
// Shared constants for the single-byte I2C master engine.
// State codes, quarter indices and slot counts used across the I2C side.
package i2c_pkg;

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] START    = 4'd1;
    localparam logic [3:0] ADDR     = 4'd2;
    localparam logic [3:0] ADDR_ACK = 4'd3;
    localparam logic [3:0] WDATA    = 4'd4;
    localparam logic [3:0] WACK     = 4'd5;
    localparam logic [3:0] RDATA    = 4'd6;
    localparam logic [3:0] RNACK    = 4'd7;
    localparam logic [3:0] STOP     = 4'd8;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int TXN_SLOTS  = 20;
    localparam int NACK_SLOTS = 11;

endpackage

// File: rtl/i2c_quarter_timer.sv
// SCL quarter-period generator: CLK_DIV prescaler plus 2-bit quarter count.
// Held at the start of Q0 while clr is high so a slot begins on acceptance.
module i2c_quarter_timer
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    output logic [1:0] q,
    output logic       q_last,
    output logic       slot_end
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    q_q, q_d;

    assign q        = q_q;
    assign q_last   = (cnt_q == CNT_MAX);
    assign slot_end = q_last && (q_q == Q3);

    always_comb begin
        cnt_d = cnt_q;
        q_d   = q_q;
        if (clr) begin
            cnt_d = '0;
            q_d   = Q0;
        end else if (q_last) begin
            cnt_d = '0;
            q_d   = q_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            q_q   <= Q0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

endmodule

// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, address, ACK, one data byte, ACK/NACK, STOP.
// Open-drain outputs are driven combinationally from the registered state.
module i2c_master_byte
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic       ready,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in
);

    logic [3:0] state_q, state_d;
    logic [6:0] addr_q;
    logic       rw_q;
    logic [7:0] wdata_q;
    logic [2:0] bit_q;
    logic       ack_err_q;
    logic [7:0] rdata_q;
    logic       done_q;

    logic [1:0] q;
    logic       q_last;
    logic       slot_end;

    i2c_quarter_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_q == IDLE),
        .q       (q),
        .q_last  (q_last),
        .slot_end(slot_end)
    );

    logic       accept;
    logic       sample;
    logic       last_bit;
    logic       shifting;
    logic [7:0] tx_byte;

    assign accept   = (state_q == IDLE) && start;
    assign sample   = q_last && (q == Q2);
    assign last_bit = slot_end && (bit_q == 3'd0);
    assign shifting = (state_q == ADDR) || (state_q == WDATA) || (state_q == RDATA);
    assign tx_byte  = (state_q == WDATA) ? wdata_q : {addr_q, rw_q};

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start)    state_d = START;
            START:    if (slot_end) state_d = ADDR;
            ADDR:     if (last_bit) state_d = ADDR_ACK;
            ADDR_ACK: if (slot_end) state_d = ack_err_q ? STOP : (rw_q ? RDATA : WDATA);
            WDATA:    if (last_bit) state_d = WACK;
            WACK:     if (slot_end) state_d = STOP;
            RDATA:    if (last_bit) state_d = RNACK;
            RNACK:    if (slot_end) state_d = STOP;
            STOP:     if (slot_end) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        unique case (state_q)
            IDLE: ;
            START: sda_oe = q[1];
            ADDR, WDATA: begin
                scl_oe = ~q[1];
                sda_oe = ~tx_byte[bit_q];
            end
            ADDR_ACK, WACK, RDATA, RNACK: scl_oe = ~q[1];
            STOP: begin
                scl_oe = ~q[1];
                sda_oe = (q != Q3);
            end
            default: ;
        endcase
    end

    assign ready   = (state_q == IDLE);
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign rdata   = rdata_q;

    // Bit counter wraps 0 -> 7 inside a byte; single-slot states reload it.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q    <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            bit_q     <= 3'd7;
            ack_err_q <= 1'b0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == STOP) && slot_end;
            if (accept) begin
                addr_q    <= addr;
                rw_q      <= rw;
                wdata_q   <= wdata;
                bit_q     <= 3'd7;
                ack_err_q <= 1'b0;
                rdata_q   <= '0;
            end
            if (slot_end) begin
                bit_q <= shifting ? bit_q - 3'd1 : 3'd7;
            end
            if (sample && sda_in && ((state_q == ADDR_ACK) || (state_q == WACK))) begin
                ack_err_q <= 1'b1;
            end
            if (sample && (state_q == RDATA)) begin
                rdata_q <= {rdata_q[6:0], sda_in};
            end
        end
    end

endmodule

// File: doc/i2c_master_byte.md
# i2c_master_byte

Single-byte I2C master engine on the I2C side of the SPI-to-I2C bridge. It consumes one decoded command from the SPI receive stage: 7-bit address, R/W, and write byte. It executes one full I2C transaction (START, address, ACK, data, ACK/NACK, STOP) on open-drain SCL/SDA, then reports completion, ACK status and the read byte back to the bridge.

## Interface
Parameters:
- CLK_DIV, default 4: clk cycles per SCL quarter-period. Legal range is ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  transaction request. Accepted only when ready=1.
- addr  in  7  target address. Captured on acceptance.
- rw  in  1  0=write, 1=read. Captured on acceptance.
- wdata  in  8  write byte. Captured on acceptance. Ignored for reads.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse when the transaction finishes.
- ack_err  out  1  1 = address or write-data NACKed. Valid from done until the next acceptance.
- rdata  out  8  read byte. Valid from done until the next acceptance.
- scl_oe  out  1  1 = pull SCL low, 0 = release.
- sda_oe  out  1  1 = pull SDA low, 0 = release.
- sda_in  in  1  sampled SDA line. Synchronised externally.

## Operation
- Reset values: ready=1, done=0, ack_err=0, rdata=0x00, scl_oe=0, sda_oe=0, state=IDLE.
- A bit slot is 4 quarters Q0..Q3. Each quarter lasts CLK_DIV clocks.
  - SCL is low in Q0–Q1 and released in Q2–Q3.
  - SDA changes only at the first clock of Q0.
  - sda_in is sampled on the last clock of Q2.
- States:
  - IDLE: on start=1, capture addr/rw/wdata, clear ack_err and rdata, go to START.
  - START (1 slot): SDA and SCL released in Q0–Q1. SDA pulled low in Q2–Q3 while SCL is released.
  - ADDR (8 slots): shift {addr,rw}, MSB first. A 0 bit drives sda_oe=1; a 1 bit releases SDA.
  - ADDR_ACK (1 slot): SDA released, sample ACK. If sda_in=1, set ack_err=1 and go to STOP. Otherwise go to WDATA if rw=0, or RDATA if rw=1.
  - WDATA (8 slots): shift wdata, MSB first.
  - WACK (1 slot): SDA released, sample ACK. If sda_in=1, set ack_err=1. Go to STOP.
  - RDATA (8 slots): SDA released, shift sda_in into rdata MSB first.
  - RNACK (1 slot): SDA released, which is the master NACK. Go to STOP.
  - STOP (1 slot): sda_oe=1 in Q0–Q2, SCL low in Q0–Q1 and released in Q2. SDA released in Q3.
  - Then done pulses for 1 cycle and the block returns to IDLE with ready=1.
- start while ready=0 is ignored. It is neither queued nor does it perturb the transaction.
- No clock stretching and no arbitration. The SCL input is not monitored.

## Timing
- Acceptance cycle is cycle 0. START Q0 begins at cycle 1.
- Full transaction (write or read, all ACKed) is 20 slots, so done is asserted at cycle 80·CLK_DIV+1. With CLK_DIV=4 this is cycle 321.
- Address NACK path is START+ADDR+ADDR_ACK+STOP = 11 slots, so done is at cycle 44·CLK_DIV+1.
- ready falls in cycle 1. It rises in the same cycle as done.
- A new start may be accepted in that same cycle, so there is no dead cycle.
- Reset mid-transaction: in the next cycle both oe signals are 0, state=IDLE and ready=1, with no done pulse.
  - The bus may be left mid-frame. Recovery is the bridge's responsibility.
- Bit counter is 3 bits and counts 7→0. The slot transition happens when the counter is 0 at the end of Q3.

## Structure
- Shared package i2c_pkg holds:
  - the state encoding localparams (IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RNACK, STOP);
  - quarter indices Q0..Q3;
  - the slot-count constants (TXN_SLOTS=20, NACK_SLOTS=11).
- Sub-module i2c_quarter_timer holds the CLK_DIV divider and the 2-bit quarter counter.
  - Its outputs are q[1:0], q_last (last clock of a quarter) and slot_end (last clock of Q3).
  - It is held cleared while in IDLE.

## Test plan
- Write, all ACK: addr=0x50, rw=0, wdata=0xA5, CLK_DIV=4, slave ACKs both slots. Required:
  - SDA bit sequence 1010000 0 [ack] 10100101 [ack];
  - done at cycle 321, ack_err=0.
- Address NACK: addr=0x27, slave leaves SDA high in ADDR_ACK. Required: no data slots, STOP follows, done at cycle 177, ack_err=1.
- Read: addr=0x3C, rw=1, slave drives 0x5A. Required: rdata=0x5A at done, and SDA released in the RNACK slot.
- Busy start: pulse start with addr=0x11 at cycle 100 of a write. Required: ignored; the original transaction completes unchanged and a single done is seen.
- Reset mid-ADDR at cycle 20. Required: next cycle scl_oe=0, sda_oe=0, ready=1, done never pulses; a following write completes normally.
- CLK_DIV=1 back-to-back: two writes, the second start held high. Required: second accepted in the done cycle, with done at cycles 81 and 162.
